// File: rtl/hssi_ss_rdy_lat_adapter.sv
// rtl/hssi_ss_rdy_lat_adapter.sv - ready-latency-N to ready-latency-0 stream adapter
// Credit-tracked register FIFO absorbs beats still in flight when the consumer stalls.
module hssi_ss_rdy_lat_adapter #(
    parameter int  DATA_WIDTH    = 64,
    parameter int  READY_LATENCY = 3,
    localparam int DEPTH         = READY_LATENCY + 2,
    localparam int FILL_W        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  in_ready,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [FILL_W-1:0]     fill_level,
    output logic                  proto_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = FILL_W + 1;

    logic [DATA_WIDTH-1:0]    mem [DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [FILL_W-1:0]        used;
    logic [READY_LATENCY-1:0] grant_sr;
    logic                     run;
    logic [CNT_W-1:0]         inflight;
    logic                     full;
    logic                     pop;
    logic                     push;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Grants in the shift register are beats that may still land; count them as occupied.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READY_LATENCY; i++) begin
            inflight = inflight + CNT_W'(grant_sr[i]);
        end
    end

    assign in_ready   = run && ((CNT_W'(used) + inflight) < CNT_W'(DEPTH));
    assign out_valid  = (used != '0);
    assign out_data   = mem[rd_ptr];
    assign fill_level = used;
    assign full       = (used == FILL_W'(DEPTH));
    assign pop        = out_valid && out_ready;
    assign push       = in_valid && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run       <= 1'b0;
            grant_sr  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            used      <= '0;
            proto_err <= 1'b0;
        end else begin
            run      <= 1'b1;
            grant_sr <= (grant_sr << 1) | READY_LATENCY'(in_ready);
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                used <= used + FILL_W'(1);
            end else if (pop && !push) begin
                used <= used - FILL_W'(1);
            end
            if (in_valid && full && !pop) begin
                proto_err <= 1'b1;
            end
        end
    end

    // Payload storage carries no reset; its contents are only observed behind out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_hssi_ss_rdy_lat_adapter.sv
// tb/tb_hssi_ss_rdy_lat_adapter.sv - self-checking bench for hssi_ss_rdy_lat_adapter
// Reference model: a beat queue plus a window of the last READY_LATENCY grant decisions.
module tb_hssi_ss_rdy_lat_adapter;

    localparam int DW    = 64;
    localparam int RL    = 3;
    localparam int DEPTH = RL + 2;
    localparam int FW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_ready;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [FW-1:0] fill_level;
    logic          proto_err;

    hssi_ss_rdy_lat_adapter #(.DATA_WIDTH(DW), .READY_LATENCY(RL)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_ready(in_ready), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .fill_level(fill_level), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    logic [DW-1:0] m_q[$];
    bit            m_hist[$];
    bit            m_run;
    bit            m_proto;
    bit            e_ready;
    bit            e_valid;
    logic [DW-1:0] e_data;
    int            e_fill;

    function automatic int hist_ones();
        int s = 0;
        foreach (m_hist[i]) s += int'(m_hist[i]);
        return s;
    endfunction

    function automatic bit due();
        return m_hist[0];
    endfunction

    task automatic model_clear();
        m_q.delete();
        m_hist.delete();
        repeat (RL) m_hist.push_back(1'b0);
        m_run   = 1'b0;
        m_proto = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Called just after a rising edge; returns at the falling edge with expectations computed.
    task automatic drive(input bit iv, input logic [DW-1:0] d, input bit ordy);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #4;
        e_ready = m_run && ((m_q.size() + hist_ones()) < DEPTH);
        e_valid = (m_q.size() != 0);
        e_data  = e_valid ? m_q[0] : 'x;
        e_fill  = m_q.size();
    endtask

    task automatic tick();
        bit pop;
        @(posedge clk);
        pop = e_valid && out_ready;
        if (pop) void'(m_q.pop_front());
        if (in_valid) begin
            if (m_q.size() < DEPTH) m_q.push_back(in_data);
            else m_proto = 1'b1;
        end
        m_hist.push_back(e_ready);
        void'(m_hist.pop_front());
        m_run = 1'b1;
        #1;
    endtask

    task automatic fill_to_full();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            drive(due(), DW'(32'h300 + k), 1'b0);
            tick();
        end
    endtask

    task automatic test_reset();
        do_reset();
        drive(1'b0, '0, 1'b0);
        n_cmp += 4;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        if (fill_level !== '0) begin n_fail++; $display("FAIL reset_fill got=%0d exp=0", fill_level); end
        if (proto_err !== 1'b0) begin n_fail++; $display("FAIL reset_proto got=%b exp=0", proto_err); end
        tick();
        drive(1'b0, '0, 1'b0);
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_first_grant got=%b exp=1", in_ready); end
        tick();
    endtask

    task automatic test_stream();
        int n = 0;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            bit iv = due();
            drive(iv, DW'(n), 1'b1);
            if (iv) n++;
            n_cmp += 4;
            if (in_ready !== e_ready) begin n_fail++; $display("FAIL stream_in_ready cyc=%0d got=%b exp=%b", i, in_ready, e_ready); end
            if (out_valid !== e_valid) begin n_fail++; $display("FAIL stream_out_valid cyc=%0d got=%b exp=%b", i, out_valid, e_valid); end
            if (fill_level > FW'(1)) begin n_fail++; $display("FAIL stream_fill cyc=%0d got=%0d exp<=1", i, fill_level); end
            if (i > 0 && in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready_held cyc=%0d got=%b exp=1", i, in_ready); end
            if (e_valid) begin
                n_cmp++;
                if (out_data !== e_data) begin n_fail++; $display("FAIL stream_data cyc=%0d got=%0h exp=%0h", i, out_data, e_data); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int rdy_cnt = 0;
        int n = 0;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            bit iv = due();
            drive(iv, DW'(32'h100 + n), 1'b0);
            if (iv) n++;
            rdy_cnt += int'(in_ready);
            n_cmp++;
            if (in_ready !== e_ready) begin n_fail++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=%b", i, in_ready, e_ready); end
            tick();
        end
        drive(1'b0, '0, 1'b0);
        n_cmp += 3;
        if (rdy_cnt != 5) begin n_fail++; $display("FAIL bp_grant_count got=%0d exp=5", rdy_cnt); end
        if (fill_level !== FW'(5)) begin n_fail++; $display("FAIL bp_fill got=%0d exp=5", fill_level); end
        if (proto_err !== 1'b0) begin n_fail++; $display("FAIL bp_proto got=%b exp=0", proto_err); end
        tick();
        for (int i = 0; i < 12; i++) begin
            bit iv = due();
            drive(iv, DW'(32'h200 + i), 1'b1);
            n_cmp += 2;
            if (in_ready !== e_ready) begin n_fail++; $display("FAIL bp_drain_ready cyc=%0d got=%b exp=%b", i, in_ready, e_ready); end
            if (out_valid !== e_valid) begin n_fail++; $display("FAIL bp_drain_valid cyc=%0d got=%b exp=%b", i, out_valid, e_valid); end
            if (e_valid) begin
                n_cmp++;
                if (out_data !== e_data) begin n_fail++; $display("FAIL bp_drain_data cyc=%0d got=%0h exp=%0h", i, out_data, e_data); end
            end
            tick();
        end
    endtask

    task automatic test_no_valid();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, '0, 1'($urandom_range(0, 1)));
            n_cmp += 2;
            if (i > 0 && in_ready !== 1'b1) begin n_fail++; $display("FAIL novalid_ready cyc=%0d got=%b exp=1", i, in_ready); end
            if (fill_level !== '0) begin n_fail++; $display("FAIL novalid_fill cyc=%0d got=%0d exp=0", i, fill_level); end
            tick();
        end
    endtask

    task automatic test_overflow();
        fill_to_full();
        drive(1'b1, DW'(32'hAA), 1'b0);
        tick();
        drive(1'b0, '0, 1'b0);
        n_cmp += 2;
        if (proto_err !== 1'b1) begin n_fail++; $display("FAIL ovf_proto got=%b exp=1", proto_err); end
        if (fill_level !== FW'(5)) begin n_fail++; $display("FAIL ovf_fill got=%0d exp=5", fill_level); end
        tick();
        repeat (4) begin drive(1'b0, '0, 1'b0); tick(); end
        drive(1'b0, '0, 1'b0);
        n_cmp++;
        if (proto_err !== 1'b1) begin n_fail++; $display("FAIL ovf_proto_sticky got=%b exp=1", proto_err); end
        tick();
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, '0, 1'b1);
            n_cmp++;
            if (out_valid !== e_valid) begin n_fail++; $display("FAIL ovf_drain_valid cyc=%0d got=%b exp=%b", i, out_valid, e_valid); end
            if (e_valid) begin
                n_cmp += 2;
                if (out_data !== e_data) begin n_fail++; $display("FAIL ovf_drain_data cyc=%0d got=%0h exp=%0h", i, out_data, e_data); end
                if (out_data === DW'(32'hAA)) begin n_fail++; $display("FAIL ovf_dropped_beat cyc=%0d got=%0h exp!=aa", i, out_data); end
            end
            tick();
        end
    endtask

    task automatic test_full_pushpop();
        int pops = 0;
        logic [DW-1:0] last = '0;
        fill_to_full();
        drive(1'b1, DW'(32'h55), 1'b1);
        n_cmp += 2;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL pp_head_valid got=%b exp=1", out_valid); end
        if (out_data !== e_data) begin n_fail++; $display("FAIL pp_head_data got=%0h exp=%0h", out_data, e_data); end
        tick();
        drive(1'b0, '0, 1'b1);
        n_cmp += 2;
        if (fill_level !== FW'(5)) begin n_fail++; $display("FAIL pp_fill got=%0d exp=5", fill_level); end
        if (proto_err !== 1'b0) begin n_fail++; $display("FAIL pp_proto got=%b exp=0", proto_err); end
        for (int i = 0; i < 6; i++) begin
            if (i > 0) drive(1'b0, '0, 1'b1);
            if (e_valid) begin
                n_cmp++;
                if (out_data !== e_data) begin n_fail++; $display("FAIL pp_drain_data cyc=%0d got=%0h exp=%0h", i, out_data, e_data); end
                last = out_data;
                pops++;
            end
            tick();
        end
        n_cmp += 2;
        if (pops != 5) begin n_fail++; $display("FAIL pp_drain_count got=%0d exp=5", pops); end
        if (last !== DW'(32'h55)) begin n_fail++; $display("FAIL pp_tail_beat got=%0h exp=55", last); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, DW'(32'h400 + k), 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b0);
        n_cmp++;
        if (fill_level !== FW'(3)) begin n_fail++; $display("FAIL arst_prefill got=%0d exp=3", fill_level); end
        rst_n = 1'b0;
        #1;
        n_cmp += 3;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_out_valid got=%b exp=0", out_valid); end
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL arst_in_ready got=%b exp=0", in_ready); end
        if (fill_level !== '0) begin n_fail++; $display("FAIL arst_fill got=%0d exp=0", fill_level); end
        do_reset();
        drive(1'b0, '0, 1'b1);
        n_cmp += 2;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL arst_release_ready got=%b exp=0", in_ready); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_release_valid got=%b exp=0", out_valid); end
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b1);
            n_cmp += 2;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_regrant cyc=%0d got=%b exp=1", i, in_ready); end
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_stale cyc=%0d got=%b exp=0", i, out_valid); end
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bit ordy = ((i / 50) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            bit iv   = due() ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 99) == 0);
            drive(iv, {$urandom, $urandom}, ordy);
            n_cmp += 4;
            if (in_ready !== e_ready) begin n_fail++; $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", i, in_ready, e_ready); end
            if (out_valid !== e_valid) begin n_fail++; $display("FAIL rand_out_valid cyc=%0d got=%b exp=%b", i, out_valid, e_valid); end
            if (fill_level !== FW'(e_fill)) begin n_fail++; $display("FAIL rand_fill cyc=%0d got=%0d exp=%0d", i, fill_level, e_fill); end
            if (proto_err !== m_proto) begin n_fail++; $display("FAIL rand_proto cyc=%0d got=%b exp=%b", i, proto_err, m_proto); end
            if (e_valid) begin
                n_cmp++;
                if (out_data !== e_data) begin n_fail++; $display("FAIL rand_data cyc=%0d got=%0h exp=%0h", i, out_data, e_data); end
            end
            tick();
        end
    endtask

    initial begin
        model_clear();
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_no_valid();
        test_overflow();
        test_full_pushpop();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
